// File: rtl/nand_bus_arbiter.sv
// nand_bus_arbiter: round-robin owner of one shared NAND pin set, idle turnaround between owners.
// Optional grant watchdog enabled by defining NAND_ARB_TIMEOUT_EN.
module nand_bus_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TURN_CYC    = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ-1:0]   DONE,
  output logic [N_REQ-1:0]   GNT,
  output logic               BUSY,
  output logic               TIMEOUT,
  input  logic [N_REQ-1:0]   REQ_CEn,
  input  logic [N_REQ-1:0]   REQ_WEn,
  input  logic [N_REQ-1:0]   REQ_REn,
  input  logic [N_REQ-1:0]   REQ_CLE,
  input  logic [N_REQ-1:0]   REQ_ALE,
  input  logic [N_REQ-1:0]   REQ_WPn,
  input  logic [N_REQ-1:0]   REQ_IO_DIR,
  input  logic [8*N_REQ-1:0] REQ_IO_OUT,
  output logic [7:0]         IO_IN,
  output logic               CEn,
  output logic               WEn,
  output logic               REn,
  output logic               CLE,
  output logic               ALE,
  output logic               WPn,
  input  logic               RDY_BSYn,
  inout  wire  [7:0]         IO
);

  localparam int SW = $clog2(N_REQ);
  localparam int TW = 4;
  localparam logic [N_REQ-1:0] ONE = 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be 2..8");
  end
  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
    $error("TURN_CYC must be 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_to
    $error("TIMEOUT_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SW-1:0]    sel;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    pick;
  logic             found;
  logic [N_REQ-1:0] gnt;
  logic [TW-1:0]    tcnt;
  logic             rel;
  logic             expire;
  logic             to_q;
  logic             io_oe;
  logic [7:0]       io_out;

  // first requester strictly after the pointer, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && REQ[(int'(ptr) + i) % N_REQ]) begin
        pick  = SW'((int'(ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

  assign rel = DONE[sel] | ~REQ[sel];

`ifdef NAND_ARB_TIMEOUT_EN
  logic [15:0] wcnt;

  assign expire = (state == GRANT) &&
                  (wcnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wcnt <= '0;
    end else if (state != GRANT) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 16'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= SW'(N_REQ - 1);
      tcnt  <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nx;
      to_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt <= ONE << pick;
            sel <= pick;
          end
        end
        GRANT: begin
          if (rel || expire) begin
            gnt  <= '0;
            ptr  <= sel;
            tcnt <= '0;
            to_q <= expire && !rel;
          end
        end
        TURN: tcnt <= tcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = GRANT;
      GRANT: if (rel || expire) state_nx = TURN;
      TURN:  if (tcnt == TW'(TURN_CYC - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // registered sel keeps the pin mux glitch-free; WPn low outside GRANT
  always_comb begin
    CEn    = 1'b1;
    WEn    = 1'b1;
    REn    = 1'b1;
    CLE    = 1'b0;
    ALE    = 1'b0;
    WPn    = 1'b0;
    io_oe  = 1'b0;
    io_out = '0;
    if (state == GRANT) begin
      CEn    = REQ_CEn[sel];
      WEn    = REQ_WEn[sel];
      REn    = REQ_REn[sel];
      CLE    = REQ_CLE[sel];
      ALE    = REQ_ALE[sel];
      WPn    = REQ_WPn[sel];
      io_oe  = REQ_IO_DIR[sel];
      io_out = REQ_IO_OUT[{sel, 3'b000} +: 8];
    end
  end

  assign IO      = io_oe ? io_out : 8'bz;
  assign IO_IN   = IO;
  assign GNT     = gnt;
  assign BUSY    = (state != IDLE);
  assign TIMEOUT = to_q;

endmodule
